// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// Zero latency: a bundle of wires with no storage.
// No backpressure here; the en/clr controls it carries are the pipeline's backpressure.
// Ports: hazard inputs (mem_*, ex_*, id_*) from the datapath; en_o/clr_o bank
// controls, MDU status and the stall performance counter back to the datapath.
interface pipe_hazard_ctrl_if #(
  parameter int CntWidth = 32
);
  logic                mem_req_i;
  logic                mem_ack_i;
  logic                ex_mdu_start_i;
  logic                ex_mem_read_i;
  logic [4:0]          ex_rt_i;
  logic [4:0]          id_rs_i;
  logic [4:0]          id_rt_i;
  logic                id_branch_taken_i;
  logic [4:0]          en_o;
  logic [4:0]          clr_o;
  logic                mdu_busy_o;
  logic                mdu_done_o;
  logic [CntWidth-1:0] stall_cnt_o;

  // Datapath side: reports hazards, receives bank controls.
  modport master (
    output mem_req_i, mem_ack_i, ex_mdu_start_i, ex_mem_read_i,
           ex_rt_i, id_rs_i, id_rt_i, id_branch_taken_i,
    input  en_o, clr_o, mdu_busy_o, mdu_done_o, stall_cnt_o
  );

  // Sequencer side.
  modport slave (
    input  mem_req_i, mem_ack_i, ex_mdu_start_i, ex_mem_read_i,
           ex_rt_i, id_rs_i, id_rt_i, id_branch_taken_i,
    output en_o, clr_o, mdu_busy_o, mdu_done_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline register banks (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// en_o/clr_o/mdu_done_o are combinational from state and hazards (0 cycles); MDU occupies EX MduLatency cycles.
// Applies backpressure by dropping bank enables; memory wait freezes everything, including MDU release.
// Ports: clk_i/rst_i (async active-high), bus (slave modport) carrying hazard inputs,
// en_o/clr_o bank controls (bit0 PC .. bit4 MEM/WB), mdu_busy_o, mdu_done_o, stall_cnt_o.
module pipe_hazard_ctrl #(
  parameter int MduLatency = 4,
  parameter int CntWidth   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  // Counter only ever holds MduLatency-2 down to 0.
  localparam int            CW      = (MduLatency > 2) ? $clog2(MduLatency) : 1;
  localparam logic [CW-1:0] CntLoad = CW'(MduLatency - 2);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state;
  logic [CW-1:0]       mdu_cnt;
  logic [CntWidth-1:0] stall_cnt;

  logic       mem_stall;
  logic       mdu_stall;
  logic       load_use;
  logic       cnt_zero;
  logic       mdu_done;
  logic [4:0] en;
  logic [4:0] clr;

  always_comb begin
    mem_stall = bus.mem_req_i & ~bus.mem_ack_i;
    cnt_zero  = (mdu_cnt == '0);
    // The first EX cycle (still IDLE) already stalls; the last BUSY cycle
    // stalls only if memory prevents the instruction from leaving EX.
    mdu_stall = ((state == IDLE) & bus.ex_mdu_start_i) |
                ((state == BUSY) & (~cnt_zero | mem_stall));
    load_use  = bus.ex_mem_read_i & (bus.ex_rt_i != 5'd0) &
                ((bus.ex_rt_i == bus.id_rs_i) | (bus.ex_rt_i == bus.id_rt_i));
    mdu_done  = (state == BUSY) & cnt_zero & ~mem_stall;

    // A taken branch is only flushed when nothing else stalls; otherwise it
    // stays in ID and gets flushed once the stall clears.
    en  = 5'b11111;
    clr = 5'b00000;
    if (mem_stall) begin
      en  = 5'b00000;
    end else if (mdu_stall) begin
      en  = 5'b11000;
      clr = 5'b01000;
    end else if (load_use) begin
      en  = 5'b11100;
      clr = 5'b00100;
    end else if (bus.id_branch_taken_i) begin
      clr = 5'b00010;
    end
  end

  // MDU occupancy FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      mdu_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A start during a memory freeze is simply retried next cycle.
          if (bus.ex_mdu_start_i && !mem_stall) begin
            state   <= BUSY;
            mdu_cnt <= CntLoad;
          end
        end
        BUSY: begin
          if (!cnt_zero) begin
            mdu_cnt <= mdu_cnt - 1'b1;
          end else if (!mem_stall) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mdu_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (!en[0] && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.en_o        = en;
  assign bus.clr_o       = clr;
  assign bus.mdu_busy_o  = (state == BUSY);
  assign bus.mdu_done_o  = mdu_done;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a driver applies one input vector per cycle and queues the
// hand-computed response; a monitor on the falling edge pops and compares.
// The counter is built 4 bits wide so saturation is reachable in a few cycles.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  typedef struct {
    string          name;
    logic [4:0]     en;
    logic [4:0]     clr;
    logic           busy;
    logic           done;
    logic [CW-1:0]  cnt;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  pipe_hazard_ctrl_if #(.CntWidth(CW)) bus ();

  pipe_hazard_ctrl #(
    .MduLatency(4),
    .CntWidth  (CW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Monitor: the DUT presents a response every cycle; check it whenever one is expected.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.en_o !== e.en || bus.clr_o !== e.clr || bus.mdu_busy_o !== e.busy ||
          bus.mdu_done_o !== e.done || bus.stall_cnt_o !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got en=%b clr=%b busy=%b done=%b cnt=%0d, want en=%b clr=%b busy=%b done=%b cnt=%0d",
                 e.name, bus.en_o, bus.clr_o, bus.mdu_busy_o, bus.mdu_done_o, bus.stall_cnt_o,
                 e.en, e.clr, e.busy, e.done, e.cnt);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic req, input logic ack,
                      input logic start, input logic rd, input logic [4:0] rt,
                      input logic [4:0] rs, input logic [4:0] irt, input logic br,
                      input logic [4:0] een, input logic [4:0] eclr, input logic ebusy,
                      input logic edone, input int ecnt);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i                 = rst;
    bus.mem_req_i         = req;
    bus.mem_ack_i         = ack;
    bus.ex_mdu_start_i    = start;
    bus.ex_mem_read_i     = rd;
    bus.ex_rt_i           = rt;
    bus.id_rs_i           = rs;
    bus.id_rt_i           = irt;
    bus.id_branch_taken_i = br;
    e.name = nm;
    e.en   = een;
    e.clr  = eclr;
    e.busy = ebusy;
    e.done = edone;
    e.cnt  = CW'(ecnt);
    exp_q.push_back(e);
  endtask

  initial begin
    bus.mem_req_i         = 1'b0;
    bus.mem_ack_i         = 1'b0;
    bus.ex_mdu_start_i    = 1'b0;
    bus.ex_mem_read_i     = 1'b0;
    bus.ex_rt_i           = 5'd0;
    bus.id_rs_i           = 5'd0;
    bus.id_rt_i           = 5'd0;
    bus.id_branch_taken_i = 1'b0;

    // name        rst req ack st rd rt rs irt br   en        clr     busy done cnt
    step("reset",   1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 0);
    step("reset2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 0);

    // Load-use: rs match, r0 exempt, rt match.
    step("lu_rs",   0, 0, 0, 0, 1, 8, 8, 0, 0, 5'b11100, 5'b00100, 0, 0, 0);
    step("lu_r0",   0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 1);
    step("lu_rt",   0, 0, 0, 0, 1, 5, 0, 5, 0, 5'b11100, 5'b00100, 0, 0, 1);
    step("lu_end",  0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 2);

    // MDU, no memory stall: 3 stall cycles then release with done.
    step("mdu_c1",  0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11000, 5'b01000, 0, 0, 2);
    step("mdu_c2",  0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11000, 5'b01000, 1, 0, 3);
    step("mdu_c3",  0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11000, 5'b01000, 1, 0, 4);
    step("mdu_dn",  0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 1, 1, 5);
    step("mdu_idl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 5);

    // MDU whose final cycle collides with a memory wait.
    step("mdm_c1",  0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11000, 5'b01000, 0, 0, 5);
    step("mdm_c2",  0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11000, 5'b01000, 1, 0, 6);
    step("mdm_c3",  0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11000, 5'b01000, 1, 0, 7);
    step("mdm_fz1", 0, 1, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 0, 8);
    step("mdm_fz2", 0, 1, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 0, 9);
    step("mdm_dn",  0, 1, 1, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 1, 1, 10);
    step("mdm_idl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 10);

    // Start during memory wait is retried; then async reset mid-BUSY (cnt=1).
    step("rty_fz",  0, 1, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 10);
    step("rty_go",  0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11000, 5'b01000, 0, 0, 11);
    step("rty_bsy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b01000, 1, 0, 12);
    step("arst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 0);
    step("arst_rl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 0);

    // Branch flush, deferred behind a load-use stall.
    step("br",      0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 5'b00010, 0, 0, 0);
    step("br_lu",   0, 0, 0, 0, 1, 3, 3, 0, 1, 5'b11100, 5'b00100, 0, 0, 0);
    step("br_late", 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 5'b00010, 0, 0, 1);
    step("br_end",  0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 1);

    // Drive the 4-bit counter into saturation and past it.
    for (int i = 0; i < 18; i++)
      step("sat",   0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0,
           (1 + i > 15) ? 15 : 1 + i);
    step("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 15);

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clk_i);
        waited++;
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain: %0d responses left unchecked, want 0", exp_q.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
